mem_port_arbiter: RTL and testbench

//  Shares the single-port 8-bit data memory between N_REQ requesters, e.g. the

---
 rtl/mem_port_arbiter.sv | 79 +++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port 8-bit data memory
// among N_REQ requesters, with optional locked bursts of up to MAX_BURST beats.
module mem_port_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ-1:0]   lock,
  input  logic [8*N_REQ-1:0] addr,
  input  logic [8*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rvalid,
  output logic [7:0]         rdata,
  output logic [7:0]         mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata
);
  localparam int OW = N_REQ > 2 ? 2 : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d, arb_ptr, cand, win;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic             hit, beat, rel;
  // Releasing owner is the pointer, so it lands at lowest priority in the re-arbitration.
  always_comb begin
    arb_ptr = state_q == BUSY ? owner_q : rr_ptr_q;
    hit = 1'b0;
    win = '0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = OW'((int'(arb_ptr) + k) % N_REQ);
      if (req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end
  always_comb begin
    beat       = state_q == BUSY && req[owner_q];
    rel        = state_q == BUSY && (!beat || !lock[owner_q] || beat_cnt_q + 4'd1 == 4'(MAX_BURST));
    gnt        = beat ? N_REQ'(1) << owner_q : '0;
    mem_read   = beat & ~we[owner_q];
    mem_write  = beat & we[owner_q];
    mem_addr   = beat ? addr[8*owner_q +: 8] : '0;
    mem_wdata  = beat ? wdata[8*owner_q +: 8] : '0;
    rdata_d    = mem_read ? mem_rdata : rdata_q;
    rvalid_d   = mem_read ? gnt : '0;
    rr_ptr_d   = rel ? owner_q : rr_ptr_q;
    state_d    = (state_q == IDLE || rel) ? (hit ? BUSY : IDLE) : state_q;
    owner_d    = (state_q == IDLE || rel) && hit ? win : owner_q;
    beat_cnt_d = (state_q == IDLE || rel) && hit ? 4'd0 : beat_cnt_q + 4'(beat);
  end
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= OW'(N_REQ - 1);
      beat_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a behavioural owner/pointer/memory model.
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int MB = 4;
  logic         CLK = 1'b0;
  logic         reset_n;
  logic [N-1:0] req, we, lock, gnt, rvalid;
  logic [8*N-1:0] addr, wdata;
  logic [7:0]   rdata, mem_addr, mem_wdata, mem_rdata;
  logic         mem_read, mem_write;
  logic [7:0]   mem     [256];
  logic [7:0]   ref_mem [256];
  int           tests = 0, fails = 0;
  int           m_owner, m_rr, m_beats;
  logic [7:0]   m_rdata;
  logic [N-1:0] m_rvalid;

  always #5 CLK = ~CLK;
  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
  always @(posedge CLK) if (mem_write) mem[mem_addr] <= mem_wdata;

  mem_port_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .CLK(CLK), .reset_n(reset_n), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(int p);
    for (int k = 1; k <= N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = N - 1; m_beats = 0; m_rdata = 8'h00; m_rvalid = '0;
  endtask

  task automatic set0();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic setr(int i, logic r, logic w, logic l, logic [7:0] a, logic [7:0] d);
    req[i] = r; we[i] = w; lock[i] = l; addr[8*i +: 8] = a; wdata[8*i +: 8] = d;
  endtask

  // Compare every DUT output with what the model says this cycle must show.
  task automatic check();
    logic [N-1:0] eg;
    logic er, ew;
    logic [7:0] ea, ed;
    @(negedge CLK);
    eg = '0; er = 0; ew = 0; ea = 0; ed = 0;
    if (m_owner >= 0 && req[m_owner]) begin
      eg = N'(1 << m_owner);
      er = !we[m_owner];
      ew = we[m_owner];
      ea = addr[8*m_owner +: 8];
      ed = wdata[8*m_owner +: 8];
    end
    chk("gnt", gnt, eg);
    chk("mem_read", mem_read, er);
    chk("mem_write", mem_write, ew);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("rvalid", rvalid, m_rvalid);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic step();
    int o, w;
    logic b;
    @(posedge CLK);
    if (!reset_n) model_reset();
    else if (m_owner < 0) begin
      m_rvalid = '0;
      w = pick(m_rr);
      if (w >= 0) begin m_owner = w; m_beats = 0; end
    end else begin
      o = m_owner;
      b = req[o];
      m_rvalid = '0;
      if (b) begin
        m_beats++;
        if (we[o]) ref_mem[addr[8*o +: 8]] = wdata[8*o +: 8];
        else begin m_rdata = ref_mem[addr[8*o +: 8]]; m_rvalid = N'(1 << o); end
      end
      if (!b || !lock[o] || m_beats == MB) begin
        m_rr = o;
        m_owner = pick(o);
        m_beats = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    set0();
    @(posedge CLK);
    #1 reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    set0();
    model_reset();
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    repeat (2) @(posedge CLK);
    #1 reset_n = 1;
    check();
    chk("reset rvalid", rvalid, 0);
    chk("reset rdata", rdata, 0);
    step();
    // single read
    setr(0, 1, 0, 0, 8'h10, 0);
    check(); chk("t1 idle gnt", gnt, 0); step();
    check(); chk("t1 gnt", gnt, 2'b01); chk("t1 read", mem_read, 1); chk("t1 addr", mem_addr, 8'h10); step();
    set0();
    check(); chk("t1 rvalid", rvalid, 2'b01); chk("t1 rdata", rdata, 8'h5A); step();
    // contention alternates
    do_reset();
    setr(0, 1, 0, 0, 8'h21, 0); setr(1, 1, 0, 0, 8'h22, 0);
    check(); chk("t2 idle gnt", gnt, 0); step();
    for (int i = 0; i < 4; i++) begin
      check(); chk("t2 alternate", gnt, i % 2 == 0 ? 2'b01 : 2'b10); step();
    end
    // burst limit
    do_reset();
    setr(1, 1, 0, 1, 8'h30, 0);
    check(); step();
    setr(0, 1, 0, 0, 8'h31, 0);
    for (int i = 0; i < MB; i++) begin
      check(); chk("t3 burst", gnt, 2'b10); step();
    end
    check(); chk("t3 handoff", gnt, 2'b01); step();
    // locked write then read
    do_reset();
    setr(0, 1, 1, 1, 8'h80, 8'hC3);
    check(); step();
    check(); chk("t4 write", mem_write, 1); chk("t4 wdata", mem_wdata, 8'hC3); chk("t4 gnt", gnt, 2'b01); step();
    setr(0, 1, 0, 0, 8'h80, 0);
    check(); chk("t4 read", mem_read, 1); chk("t4 no write", mem_write, 0); step();
    set0();
    check(); chk("t4 rvalid", rvalid, 2'b01); chk("t4 rdata", rdata, 8'hC3); step();
    // reset during a write beat
    do_reset();
    mem[8'h40] = 8'h11; ref_mem[8'h40] = 8'h11;
    setr(0, 1, 1, 1, 8'h40, 8'hEE);
    check(); step();
    check(); chk("t5 write beat", mem_write, 1);
    #1 reset_n = 0;
    model_reset();
    #1;
    chk("t5 gnt cleared", gnt, 0); chk("t5 write cleared", mem_write, 0); chk("t5 rvalid cleared", rvalid, 0);
    @(posedge CLK);
    #1 chk("t5 mem kept", mem[8'h40], 8'h11);
    reset_n = 1;
    setr(0, 1, 0, 0, 8'h40, 0);
    check(); chk("t5 idle after reset", gnt, 0); step();
    check(); chk("t5 regrant", gnt, 2'b01); step();
    set0();
    check(); chk("t5 read old", rdata, 8'h11); step();
    // abort while locked
    do_reset();
    setr(0, 1, 0, 1, 8'h10, 0);
    check(); step();
    check(); chk("t6 gnt", gnt, 2'b01); step();
    setr(0, 0, 0, 1, 8'h10, 0); setr(1, 1, 0, 0, 8'h20, 0);
    check(); chk("t6 abort gnt", gnt, 0); chk("t6 abort rd", mem_read, 0); chk("t6 abort wr", mem_write, 0); step();
    check(); chk("t6 next owner", gnt, 2'b10); step();
    // random traffic
    do_reset();
    repeat (600) begin
      for (int i = 0; i < N; i++)
        setr(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             8'hA0 + 8'($urandom_range(0, 7)), 8'($urandom));
      check();
      chk("rand excl", mem_read & mem_write, 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
